// File: rtl/dest_fifo_reader.sv
// Drains destination FIFOs D0/D1 into one tagged stream with per-destination saturating counters.
// Define READER_STRICT_PRIO_EN to give D0 strict priority instead of round-robin arbitration.
module dest_fifo_reader #(
    parameter int BW    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             sink_ready,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic             D0_error_output,
    input  logic             D1_error_output,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    output logic [BW-1:0]    data_out,
    output logic             valid_out,
    output logic             dest_out,
    output logic [CNT_W-1:0] d0_count,
    output logic [CNT_W-1:0] d1_count,
    output logic             idle_out,
    output logic             error_out
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_next;
    logic   any_error;
    logic   can_pop;
    logic   elig0;
    logic   elig1;
    logic   grant0;
    logic   grant1;
    logic   pop;

    // A pop during reset would lose a FIFO word, so reset also blocks pops.
    assign any_error = D0_error_output | D1_error_output;
    assign can_pop   = !reset && (state == ACTIVE) && init && sink_ready && !any_error;
    assign elig0     = can_pop && !D0_empty;
    assign elig1     = can_pop && !D1_empty;

`ifdef READER_STRICT_PRIO_EN
    assign grant0 = elig0;
    assign grant1 = elig1 && !elig0;
`else
    logic last_grant;

    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (pop)
            last_grant <= grant1;
    end
`endif

    assign pop   = grant0 | grant1;
    assign D0_rd = grant0;
    assign D1_rd = grant1;

    // The FIFO presents the popped word one cycle after rd, aligned with valid_out.
    assign data_out = valid_out ? (dest_out ? D1_data_out : D0_data_out) : '0;

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_next = state;
        if (any_error) begin
            state_next = HALT;
        end else begin
            case (state)
                IDLE:    if (init) state_next = ACTIVE;
                ACTIVE:  if (!init && !pop) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            dest_out  <= 1'b0;
            d0_count  <= '0;
            d1_count  <= '0;
            idle_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            state     <= state_next;
            valid_out <= pop;
            dest_out  <= grant1;
            if (grant0 && d0_count != CNT_MAX)
                d0_count <= d0_count + 1'b1;
            if (grant1 && d1_count != CNT_MAX)
                d1_count <= d1_count + 1'b1;
            idle_out  <= (state_next == IDLE) && !pop;
            error_out <= (state_next == HALT);
        end
    end

endmodule
